// File: rtl/demux_pkg.sv
// Shared definitions for the 1:8 demux stage and its bit sequencer.
// Lane count, state encoding and hold-counter sizing live here.
package demux_pkg;

    localparam int SEL_W_DEF  = 3;
    localparam int HOLD_MAX   = 15;
    localparam int HOLD_CNT_W = 4;

    function automatic int lane_count(input int sel_w);
        return 1 << sel_w;
    endfunction

    localparam int N_DEF = lane_count(SEL_W_DEF);

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SEND = 1'b1;

endpackage

// File: rtl/hold_counter.sv
// Free-running pacing counter with synchronous clear and a terminal-count
// flag; used to hold each sequencer output for a programmable cycle count.
module hold_counter
    import demux_pkg::*;
#(
    parameter int W = HOLD_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/demux_bit_sequencer.sv
// Serialises a parallel word into (i, s) pairs for the downstream 1:N demux.
// Define DEMUX_SEQ_DESCEND_EN to sweep lanes from N-1 down to 0.
module demux_bit_sequencer
    import demux_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int HOLD  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [(1 << SEL_W)-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     i,
    output logic [SEL_W-1:0]         s,
    output logic                     bit_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int N = lane_count(SEL_W);

    localparam logic [HOLD_CNT_W-1:0] LIMIT = HOLD_CNT_W'(HOLD - 1);

`ifdef DEMUX_SEQ_DESCEND_EN
    localparam logic [SEL_W-1:0] FIRST = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] LAST  = '0;
`else
    localparam logic [SEL_W-1:0] FIRST = '0;
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);
`endif

    state_t           state;
    state_t           state_n;
    logic [N-1:0]     word;
    logic [N-1:0]     word_n;
    logic [SEL_W-1:0] s_n;
    logic [SEL_W-1:0] s_step;
    logic             i_n;
    logic             done_n;

    logic                  cnt_clr;
    logic                  cnt_en;
    logic [HOLD_CNT_W-1:0] count;
    logic                  tc;

    logic accept;
    logic last;

    hold_counter #(
        .W (HOLD_CNT_W)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (LIMIT),
        .count (count),
        .tc    (tc)
    );

    assign accept = in_valid && in_ready;
    assign last   = (s == LAST);

`ifdef DEMUX_SEQ_DESCEND_EN
    assign s_step = s - SEL_W'(1);
`else
    assign s_step = s + SEL_W'(1);
`endif

    always_comb begin
        state_n = state;
        word_n  = word;
        s_n     = s;
        i_n     = i;
        done_n  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (1'b1)
            (state == ST_IDLE): begin
                if (accept) begin
                    state_n = ST_SEND;
                    word_n  = in_data;
                    s_n     = FIRST;
                    i_n     = in_data[FIRST];
                    cnt_clr = 1'b1;
                    done_n  = (FIRST == LAST) && (LIMIT == '0);
                end
            end
            (state == ST_SEND): begin
                cnt_en = 1'b1;
                if (tc) begin
                    cnt_clr = 1'b1;
                    if (last) begin
                        state_n = ST_IDLE;
                        s_n     = '0;
                        i_n     = 1'b0;
                    end else begin
                        s_n    = s_step;
                        i_n    = word[s_step];
                        done_n = (s_step == LAST) && (LIMIT == '0);
                    end
                end else begin
                    // done must line up with the last hold cycle of the last lane
                    done_n = last && ((count + HOLD_CNT_W'(1)) == LIMIT);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word      <= '0;
            s         <= '0;
            i         <= 1'b0;
            done      <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            word      <= word_n;
            s         <= s_n;
            i         <= i_n;
            done      <= done_n;
            bit_valid <= (state_n == ST_SEND);
            busy      <= (state_n == ST_SEND);
            in_ready  <= (state_n == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Scoreboard bench: two sequencers (HOLD=1 and HOLD=3) driven by directed words.
module tb_demux_bit_sequencer;

    typedef struct packed {
        logic       i;
        logic [2:0] s;
        logic       done;
    } exp_t;

    localparam int HOLDS [2] = '{1, 3};

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data  [2];
    logic       in_valid [2];
    logic       rdy      [2];
    logic       iv       [2];
    logic [2:0] sv       [2];
    logic       bv       [2];
    logic       bz       [2];
    logic       dn       [2];

    exp_t q [2][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc [2];

    demux_bit_sequencer #(.SEL_W(3), .HOLD(1)) u_h1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (rdy[0]),
        .i         (iv[0]),
        .s         (sv[0]),
        .bit_valid (bv[0]),
        .busy      (bz[0]),
        .done      (dn[0])
    );

    demux_bit_sequencer #(.SEL_W(3), .HOLD(3)) u_h3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (rdy[1]),
        .i         (iv[1]),
        .s         (sv[1]),
        .bit_valid (bv[1]),
        .busy      (bz[1]),
        .done      (dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    function automatic logic [2:0] lane_of(input int k);
`ifdef DEMUX_SEQ_DESCEND_EN
        return 3'(7 - k);
`else
        return 3'(k);
`endif
    endfunction

    // Monitor: every sampled cycle either pops one expected bit or must look idle.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < 2; j++) begin
                if (bv[j]) begin
                    checks++;
                    if (q[j].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_bit dut%0d: got s=%0d i=%0b, required no output",
                                 j, sv[j], iv[j]);
                    end else begin
                        exp_t e;
                        e = q[j].pop_front();
                        if ({iv[j], sv[j], dn[j], bz[j], rdy[j]} !==
                            {e.i, e.s, e.done, 1'b1, 1'b0}) begin
                            errors++;
                            $display("FAIL bit dut%0d: got i=%0b s=%0d done=%0b busy=%0b rdy=%0b, required i=%0b s=%0d done=%0b busy=1 rdy=0",
                                     j, iv[j], sv[j], dn[j], bz[j], rdy[j], e.i, e.s, e.done);
                        end
                    end
                end else begin
                    checks++;
                    if ({iv[j], sv[j], dn[j], bz[j], rdy[j]} !== 7'b0_000_0_0_1) begin
                        errors++;
                        $display("FAIL idle dut%0d: got i=%0b s=%0d done=%0b busy=%0b rdy=%0b, required i=0 s=0 done=0 busy=0 rdy=1",
                                 j, iv[j], sv[j], dn[j], bz[j], rdy[j]);
                    end
                end
            end
        end
    end

    task automatic check_reset(input string name);
        for (int j = 0; j < 2; j++) begin
            checks++;
            if ({rdy[j], iv[j], sv[j], bv[j], bz[j], dn[j]} !== 8'b1_0_000_0_0_0) begin
                errors++;
                $display("FAIL %s dut%0d: got rdy=%0b i=%0b s=%0d bv=%0b busy=%0b done=%0b, required rdy=1 others 0",
                         name, j, rdy[j], iv[j], sv[j], bv[j], bz[j], dn[j]);
            end
        end
    endtask

    task automatic send(input int j, input logic [7:0] w, input bit keep);
        int t = 0;
        in_data[j]  = w;
        in_valid[j] = 1'b1;
        while (!rdy[j] && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (!rdy[j]) begin
            errors++;
            $display("FAIL ready_timeout dut%0d: got rdy=0, required rdy=1", j);
            in_valid[j] = 1'b0;
            return;
        end
        @(posedge clk);
        acc_cyc[j] = cyc;
        for (int k = 0; k < 8 * HOLDS[j]; k++) begin
            exp_t e;
            e.s    = lane_of(k / HOLDS[j]);
            e.i    = w[e.s];
            e.done = (k == 8 * HOLDS[j] - 1);
            q[j].push_back(e);
        end
        #1;
        if (!keep) in_valid[j] = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int j);
        int t = 0;
        while ((q[j].size() != 0 || !rdy[j]) && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL idle_timeout dut%0d: got %0d bits pending, required 0", j, q[j].size());
        end
    endtask

    initial begin
        int first_acc;
        int t;
        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_data[j]  = '0;
            in_valid[j] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Word 8'hA5 at HOLD=1 alongside 8'hFF at HOLD=3
        fork
            begin send(0, 8'hA5, 1'b0); wait_idle(0); end
            begin send(1, 8'hFF, 1'b0); wait_idle(1); end
        join

        // Back-to-back with in_valid held high
        send(0, 8'h01, 1'b1);
        first_acc = acc_cyc[0];
        send(0, 8'h80, 1'b0);
        checks++;
        if (acc_cyc[0] - first_acc != 9) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles between accepts, required 9",
                     acc_cyc[0] - first_acc);
        end
        wait_idle(0);

        // in_valid pulse during SEND must be ignored
        send(0, 8'hC3, 1'b0);
        @(negedge clk);
        #1;
        in_data[0]  = 8'h3C;
        in_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        in_valid[0] = 1'b0;
        wait_idle(0);

        // Reset mid-word at lane 4
        send(0, 8'hAA, 1'b0);
        t = 0;
        while (!(bv[0] && sv[0] == 3'd4) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL lane4_timeout: got s=%0d, required s=4", sv[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_word_reset");
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        send(0, 8'h0F, 1'b0);
        wait_idle(0);

        // Single set bit: lane 0 only, checks sweep direction of the build
        send(0, 8'h01, 1'b0);
        wait_idle(0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
